// File: rtl/rr_mux_n_if.sv
// Handshake bundle for rr_mux_n: N valid/ready input channels merged onto one registered output.
// in_last and its modport entries exist only when RR_MUX_LOCK_EN is defined.
interface rr_mux_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
`ifdef RR_MUX_LOCK_EN
  logic [N-1:0]       in_last;
`endif
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;

`ifdef RR_MUX_LOCK_EN
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
`else
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );
`endif
endinterface

// File: rtl/rr_mux_n.sv
// N-channel round-robin arbitrated mux with a single registered output stage.
// Define RR_MUX_LOCK_EN to compile in burst locking driven by in_last.
module rr_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_mux_n_if.slave bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
`ifdef RR_MUX_LOCK_EN
  logic             lock_q, lock_d;
`endif

  logic [SELW:0]    pick;
  logic             found;
  logic [SELW-1:0]  win;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] win_data;
  logic [N-1:0]     ready;

  // Returns {found, index} of the first valid channel searching ptr+1, ptr+2, ... with wrap.
  function automatic logic [SELW:0] rr_pick(input logic [N-1:0] vld, input logic [SELW-1:0] ptr);
    logic [SELW:0] res;
    int            idx;
    res = {1'b0, ptr};
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!res[SELW] && vld[idx]) res = {1'b1, SELW'(idx)};
    end
    return res;
  endfunction

  // Arbitration: a held burst pins the grant to the channel last served.
  always_comb begin
    pick = rr_pick(bus.in_valid, ptr_q);
`ifdef RR_MUX_LOCK_EN
    if (lock_q) pick = {bus.in_valid[ptr_q], ptr_q};
`endif
    found    = pick[SELW];
    win      = pick[SELW-1:0];
    load     = !out_valid_q || bus.out_ready;
    accept   = rst_n && load && found;
    win_data = bus.in_data[int'(win)*WIDTH +: WIDTH];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) out_valid_d = found;
    if (accept) begin
      out_data_d = win_data;
      out_sel_d  = win;
      ptr_d      = win;
    end
  end

`ifdef RR_MUX_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    if (accept) lock_d = !bus.in_last[win];
  end
`endif

  always_comb begin
    ready = '0;
    if (accept) ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SELW'(N-1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef RR_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`endif

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural round-robin model.
module tb_rr_mux_n;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic clk = 1'b0;
  logic rst_n;

  rr_mux_n_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

  rr_mux_n #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [N-1:0] ready_snap = '0;

  // Model state: what the output register holds, the channel served last, burst lock.
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_last;
  bit               m_lock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit           load;
    bit           found;
    int           g;
    logic [N-1:0] exp_rdy;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_last  = N - 1;
      m_lock  = 1'b0;
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_out_data", 64'(bus.out_data), 64'(0));
      check("rst_out_sel", 64'(bus.out_sel), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    end else begin
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("out_data", 64'(bus.out_data), 64'(m_data));
      check("out_sel", 64'(bus.out_sel), 64'(m_sel));
      load  = !m_valid || bus.out_ready;
      found = 1'b0;
      g     = 0;
      if (m_lock) begin
        found = bus.in_valid[m_last];
        g     = m_last;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!found && bus.in_valid[(m_last + k) % N]) begin
            found = 1'b1;
            g     = (m_last + k) % N;
          end
        end
      end
      exp_rdy = '0;
      if (load && found) exp_rdy[g] = 1'b1;
      check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      if (load) begin
        m_valid = found;
        if (found) begin
          m_data = bus.in_data[g*WIDTH +: WIDTH];
          m_sel  = g;
          m_last = g;
`ifdef RR_MUX_LOCK_EN
          m_lock = !bus.in_last[g];
`endif
        end
      end
    end
  end

  // Advance one cycle; capture the grant seen before the edge, return just after the edge.
  task automatic tick();
    @(negedge clk);
    #1;
    ready_snap = bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input bit v, input logic [WIDTH-1:0] d);
    bus.in_valid[i]            = v;
    bus.in_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bit v;
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef RR_MUX_LOCK_EN
    bus.in_last   = '1;
`endif

    // All four channels valid: reset state, then sequence 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_ch(i, 1'b1, 32'hA0 + 32'(i));
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("t1_rst_valid", 64'(bus.out_valid), 64'(0));
    check("t1_rst_data", 64'(bus.out_data), 64'(0));
    check("t1_rst_ready", 64'(bus.in_ready), 64'(0));
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t1_valid", 64'(bus.out_valid), 64'(1));
      check("t1_sel", 64'(bus.out_sel), 64'(k % 4));
      check("t1_data", 64'(bus.out_data), 64'(32'hA0 + 32'(k % 4)));
    end

    // Only channel 2 valid; the others carry X data.
    for (int i = 0; i < N; i++) set_ch(i, i == 2, (i == 2) ? 32'h1234 : 'x);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_data", 64'(bus.out_data), 64'h1234);
      check("t2_sel", 64'(bus.out_sel), 64'(2));
      check("t2_ready", 64'(bus.in_ready), 64'(4'b0100));
    end

    // Back-pressure on 0xBEEF from channel 1, then channel 3 wins.
    for (int i = 0; i < N; i++) set_ch(i, i == 1, (i == 1) ? 32'hBEEF : 'x);
    tick();
    check("t3_load_data", 64'(bus.out_data), 64'hBEEF);
    bus.out_ready = 1'b0;
    set_ch(0, 1'b1, 32'h10);
    set_ch(1, 1'b0, 'x);
    set_ch(3, 1'b1, 32'h13);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_hold_data", 64'(bus.out_data), 64'hBEEF);
      check("t3_hold_sel", 64'(bus.out_sel), 64'(1));
      check("t3_hold_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    tick();
    check("t3_next_sel", 64'(bus.out_sel), 64'(3));
    check("t3_next_data", 64'(bus.out_data), 64'h13);

    // Reset pulse mid-stream with channels 1 and 3 valid.
    for (int i = 0; i < N; i++) set_ch(i, (i == 1) || (i == 3), 32'h20 + 32'(i));
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t4_async_valid", 64'(bus.out_valid), 64'(0));
    check("t4_async_ready", 64'(bus.in_ready), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_first_sel", 64'(bus.out_sel), 64'(1));
    check("t4_first_data", 64'(bus.out_data), 64'h21);

`ifdef RR_MUX_LOCK_EN
    // Three-beat burst on channel 1 while channel 2 waits.
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 1'b0, 'x);
    bus.in_last = '1;
    set_ch(1, 1'b1, 32'hB1);
    bus.in_last[1] = 1'b0;
    set_ch(2, 1'b1, 32'hC2);
    tick();
    check("l1_beat1_sel", 64'(bus.out_sel), 64'(1));
    check("l1_beat1_ready", 64'(bus.in_ready), 64'(4'b0010));
    set_ch(1, 1'b1, 32'hB2);
    tick();
    check("l1_beat2_sel", 64'(bus.out_sel), 64'(1));
    check("l1_beat2_data", 64'(bus.out_data), 64'hB2);
    set_ch(1, 1'b1, 32'hB3);
    bus.in_last[1] = 1'b1;
    tick();
    check("l1_beat3_sel", 64'(bus.out_sel), 64'(1));
    check("l1_unlock_ready", 64'(bus.in_ready), 64'(4'b0100));
    set_ch(1, 1'b0, 'x);
    tick();
    check("l1_after_sel", 64'(bus.out_sel), 64'(2));

    // Locked channel 0 stalls for two cycles; channel 3 must wait.
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 1'b0, 'x);
    bus.in_last = '1;
    set_ch(0, 1'b1, 32'hD0);
    bus.in_last[0] = 1'b0;
    set_ch(3, 1'b1, 32'hD3);
    tick();
    check("l2_first_sel", 64'(bus.out_sel), 64'(0));
    set_ch(0, 1'b0, 'x);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("l2_bubble_valid", 64'(bus.out_valid), 64'(0));
      check("l2_bubble_ready", 64'(bus.in_ready), 64'(0));
    end
    set_ch(0, 1'b1, 32'hD1);
    bus.in_last[0] = 1'b1;
    tick();
    check("l2_resume_sel", 64'(bus.out_sel), 64'(0));
    check("l2_resume_data", 64'(bus.out_data), 64'hD1);
    set_ch(0, 1'b0, 'x);
    tick();
    check("l2_release_sel", 64'(bus.out_sel), 64'(3));
`endif

    // Random traffic obeying hold-until-ready, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(bus.in_valid[i] && !ready_snap[i])) begin
          v = ($urandom_range(99) < 55);
          set_ch(i, v, v ? $urandom : 'x);
`ifdef RR_MUX_LOCK_EN
          bus.in_last[i] = ($urandom_range(2) != 0);
`endif
        end
      end
      bus.out_ready = ($urandom_range(99) < 70);
      rst_n = ($urandom_range(299) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
